// File: rtl/ctrl_pipe_hazard.sv
// Control-word pipeline (EX/MEM/WB) with RAW hazard detection against all three writer stages.
// Stalls decode and injects bubbles on a hazard; counts stall cycles with a saturating counter.
module ctrl_pipe_hazard #(
  parameter int CW     = 32,
  parameter int CNT_W  = 16,
  parameter int R0_HAZ = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CW-1:0]    ctrl_in,
  input  logic             ctrl_valid,
  output logic             stall,
  output logic [CW-1:0]    ex_ctrl,
  output logic [CW-1:0]    mem_ctrl,
  output logic [CW-1:0]    wb_ctrl,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CW-1:0] BUBBLE = '0;

  logic [4:0] src_rs;
  logic [4:0] src_rt;
  logic       dec_active;
  logic       rt_used;
  logic       unused_fields;

  assign src_rs     = ctrl_in[26:22];
  assign src_rt     = ctrl_in[21:17];
  assign dec_active = ctrl_valid & (ctrl_in[5] | ctrl_in[7]);
  assign rt_used    = dec_active & (~ctrl_in[10] | ctrl_in[7]);

  assign unused_fields = ^{ctrl_in[CW-1:27], ctrl_in[16:11], ctrl_in[9:8], ctrl_in[6], ctrl_in[4:0]};

  // A stage only counts as a writer when its wb_en is set; r0 is exempt unless R0_HAZ.
  function automatic logic writes_reg(input logic [CW-1:0] word, input logic [4:0] r);
    return word[5] && (word[4:0] == r) && ((r != 5'd0) || (R0_HAZ != 0));
  endfunction

  // No forwarding and no RF write-through, so EX, MEM and WB are all live hazards.
  always_comb begin
    stall = 1'b0;
    if (dec_active) begin
      stall = writes_reg(ex_ctrl, src_rs) | writes_reg(mem_ctrl, src_rs) |
              writes_reg(wb_ctrl, src_rs);
    end
    if (rt_used) begin
      stall = stall | writes_reg(ex_ctrl, src_rt) | writes_reg(mem_ctrl, src_rt) |
              writes_reg(wb_ctrl, src_rt);
    end
  end

  // Downstream stages always advance; only the decode-to-EX hand-off is gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl  <= BUBBLE;
      mem_ctrl <= BUBBLE;
      wb_ctrl  <= BUBBLE;
    end else begin
      ex_ctrl  <= (stall || !ctrl_valid) ? BUBBLE : ctrl_in;
      mem_ctrl <= ex_ctrl;
      wb_ctrl  <= mem_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign rf_we    = wb_ctrl[5];
  assign rf_waddr = wb_ctrl[4:0];

endmodule
